// File: rtl/parallel_xnor_sched.sv
// Round-robin scheduler sharing one bitwise XNOR datapath between R requesters,
// with a single-entry registered response and a saturating equal-result counter.

module parallel_gate_xnor #(
    parameter int S = 3
) (
    input  logic [2**S-1:0] in1,
    input  logic [2**S-1:0] in2,
    output logic [2**S-1:0] out
);
    assign out = ~(in1 ^ in2);
endmodule

module parallel_xnor_sched #(
    parameter int S = 3,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [R-1:0]         req_valid,
    input  logic [R*(2**S)-1:0]  req_a,
    input  logic [R*(2**S)-1:0]  req_b,
    output logic [R-1:0]         req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(R)-1:0] rsp_id,
    output logic [2**S-1:0]      rsp_xnor,
    output logic                 rsp_eq,
    output logic [15:0]          match_cnt
);
    localparam int W   = 2**S;
    localparam int IDW = $clog2(R);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_xnor_q, rsp_xnor_d;
    logic             rsp_eq_q, rsp_eq_d;
    logic [15:0]      match_cnt_q, match_cnt_d;

    logic             acc;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic             grant;
    logic [W-1:0]     sel_a, sel_b, xnor_out;

    // Rotating priority search: first valid requester at or after ptr, modulo R.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < R; k++) begin
            if (!gnt_any && req_valid[(int'(ptr_q) + k) % R]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((int'(ptr_q) + k) % R);
            end
        end
    end

    assign acc       = (state_q == EMPTY) || rsp_ready;
    assign grant     = acc && gnt_any && !reset;
    assign req_ready = grant ? (R'(1) << gnt_idx) : '0;

    assign sel_a = req_a[gnt_idx*W +: W];
    assign sel_b = req_b[gnt_idx*W +: W];

    parallel_gate_xnor #(.S(S)) u_xnor (
        .in1 (sel_a),
        .in2 (sel_b),
        .out (xnor_out)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_xnor_d  = rsp_xnor_q;
        rsp_eq_d    = rsp_eq_q;
        match_cnt_d = match_cnt_q;

        // Count on the outgoing handshake, so a result lost to reset is never counted.
        if (state_q == FULL && rsp_ready && rsp_eq_q && match_cnt_q != 16'hFFFF)
            match_cnt_d = match_cnt_q + 16'd1;

        if (grant) begin
            state_d    = FULL;
            rsp_id_d   = gnt_idx;
            rsp_xnor_d = xnor_out;
            rsp_eq_d   = &xnor_out;
            ptr_d      = (gnt_idx == IDW'(R - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_xnor_q  <= '0;
            rsp_eq_q    <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_xnor_q  <= rsp_xnor_d;
            rsp_eq_q    <= rsp_eq_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_xnor  = rsp_xnor_q;
    assign rsp_eq    = rsp_eq_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_parallel_xnor_sched.sv
// Self-checking bench for parallel_xnor_sched: directed vector table, async reset,
// random traffic against a behavioural model, and counter saturation.

module tb_parallel_xnor_sched;
    localparam int S   = 3;
    localparam int R   = 4;
    localparam int W   = 2**S;
    localparam int IDW = $clog2(R);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [R-1:0]         req_valid;
    logic [R*W-1:0]       req_a, req_b;
    logic [R-1:0]         req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_xnor;
    logic                 rsp_eq;
    logic [15:0]          match_cnt;

    parallel_xnor_sched #(.S(S), .R(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_xnor  (rsp_xnor),
        .rsp_eq    (rsp_eq),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    bit          m_valid;
    int          m_id;
    logic [W-1:0] m_xnor;
    bit          m_eq;
    int          m_cnt;
    int          m_ptr;
    logic [R-1:0] seen_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_id = 0; m_xnor = '0; m_eq = 0; m_cnt = 0; m_ptr = 0;
    endfunction

    // One clock cycle: drive after the falling edge, check grant mid-cycle,
    // check the registered response just after the rising edge.
    task automatic step(input logic [R-1:0] v, input logic [R*W-1:0] a,
                        input logic [R*W-1:0] b, input logic rr, input bit chk);
        int g;
        logic [R-1:0] exp_ready;
        logic [W-1:0] sa, sb;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        g = -1;
        if (!m_valid || rr)
            for (int k = 0; k < R; k++)
                if (g < 0 && v[(m_ptr + k) % R]) g = (m_ptr + k) % R;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        seen_ready = req_ready;
        if (chk) check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (m_valid && rr && m_eq && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
            sa = a[g*W +: W];
            sb = b[g*W +: W];
            m_valid = 1;
            m_id    = g;
            m_xnor  = ~(sa ^ sb);
            m_eq    = (sa == sb);
            m_ptr   = (g + 1) % R;
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
        if (chk) begin
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                check("rsp_id", 32'(rsp_id), 32'(m_id));
                check("rsp_xnor", 32'(rsp_xnor), 32'(m_xnor));
                check("rsp_eq", 32'(rsp_eq), 32'(m_eq));
            end
            check("match_cnt", 32'(match_cnt), 32'(m_cnt));
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [R-1:0]   v;
        logic [R*W-1:0] a, b;
        logic           rr;
        logic [R-1:0]   e_ready;
        logic           e_valid;
        logic [IDW-1:0] e_id;
        logic [W-1:0]   e_xnor;
        logic           e_eq;
        logic [15:0]    e_cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] a0, ar, br, ap, bp, eq_ab;
        a0 = 32'h00A50000;
        ar = 32'h03020100; br = 32'h03FF0100;
        ap = 32'h03020F00; bp = 32'h03FFF000;

        // Single request, drain, round-robin, backpressure, pointer skip/wrap.
        tbl[0]  = '{4'b0100, a0, a0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hFF, 1'b1, 16'd0};
        tbl[1]  = '{4'b0000, a0, a0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd1};
        tbl[2]  = '{4'b1111, ar, br, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hFF, 1'b1, 16'd1};
        tbl[3]  = '{4'b1111, ar, br, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hFF, 1'b1, 16'd2};
        tbl[4]  = '{4'b1111, ar, br, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hFF, 1'b1, 16'd3};
        tbl[5]  = '{4'b1111, ar, br, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h02, 1'b0, 16'd4};
        tbl[6]  = '{4'b1111, ar, br, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hFF, 1'b1, 16'd4};
        tbl[7]  = '{4'b1111, ar, br, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hFF, 1'b1, 16'd5};
        tbl[8]  = '{4'b0010, ap, bp, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00, 1'b0, 16'd6};
        for (int i = 9; i <= 13; i++)
            tbl[i] = '{4'b1111, ap, bp, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h00, 1'b0, 16'd6};
        tbl[14] = '{4'b1111, ap, bp, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h02, 1'b0, 16'd6};
        tbl[15] = '{4'b0010, ap, bp, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00, 1'b0, 16'd6};
        tbl[16] = '{4'b1000, ap, bp, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hFF, 1'b1, 16'd6};
        tbl[17] = '{4'b0000, ap, bp, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd7};

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        model_reset();
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr, 1'b1);
            check($sformatf("tbl%0d_ready", i), 32'(seen_ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_cnt", i), 32'(match_cnt), 32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
                check($sformatf("tbl%0d_xnor", i), 32'(rsp_xnor), 32'(tbl[i].e_xnor));
                check($sformatf("tbl%0d_eq", i), 32'(rsp_eq), 32'(tbl[i].e_eq));
            end
        end

        // Async reset with a response pending and a nonzero count: clears before any edge.
        step(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_id", 32'(rsp_id), 32'd0);
        check("arst_rsp_xnor", 32'(rsp_xnor), 32'd0);
        check("arst_rsp_eq", 32'(rsp_eq), 32'd0);
        check("arst_match_cnt", 32'(match_cnt), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? ra : ($urandom ^ ($urandom & ra));
            step(R'($urandom), ra, rb, ($urandom_range(0, 3) != 0), 1'b1);
        end

        // Saturation: 65,537 equal results back to back, then it must hold at 0xFFFF.
        eq_ab = $urandom;
        for (int n = 0; n < 65537; n++)
            step(4'b1111, eq_ab, eq_ab, 1'b1, 1'b0);
        check("sat_cnt", 32'(match_cnt), 32'hFFFF);
        for (int n = 0; n < 4; n++)
            step(4'b1111, eq_ab, eq_ab, 1'b1, 1'b1);
        check("sat_hold", 32'(match_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
